xrv_dmem_resp: RTL and testbench

// - Responder (memory end) of the core's d_* data bus. Serves load/store requests from the execute stage.
// - Backing store is a byte-enabled synchronous RAM; WAIT_CYCLES adds programmable wait states.
// - Sits between the xrv core data port and on-chip data RAM.
// - Out-of-range accesses are still acknowledged and are flagged on a sticky error output.

---
 rtl/xrv_pkg.sv | 14 +
 rtl/xrv_dmem_ram.sv | 37 +++
 rtl/xrv_dmem_resp.sv | 157 +++++++++++++++
 tb/tb_xrv_dmem_resp.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xrv_pkg.sv
// xrv_pkg: shared types and constants for the xrv data-memory responder.
//   dmem_state_e   : responder FSM states (idle, wait states, response)
//   DMEM_MISS_DATA : word returned for reads that miss the RAM window
package xrv_pkg;

  typedef enum logic [1:0] {
    DM_IDLE,
    DM_WAIT,
    DM_RESP
  } dmem_state_e;

  localparam logic [31:0] DMEM_MISS_DATA = 32'h0;

endpackage

// File: rtl/xrv_dmem_ram.sv
// xrv_dmem_ram: 2^DEPTH_LOG2 x 32 single-port synchronous RAM with byte lanes.
//   clk      : clock
//   addr_i   : word index shared by read and write
//   we_i     : per-lane write enables, lane i = wdata_i[8i+7:8i]
//   re_i     : read enable; rdata_o updates on the following edge
//   wdata_i  : lane-aligned write data
//   rdata_o  : registered read word, held until the next read
// Contents are not reset.
module xrv_dmem_ram #(
  parameter int DEPTH_LOG2 = 14,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [3:0]            we_i,
  input  logic                  re_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  (* ram_style = "block" *) logic [31:0] mem_q [2**DEPTH_LOG2];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/xrv_dmem_resp.sv
// xrv_dmem_resp: memory-side responder for the xrv core d_* data bus.
//   clk, rstb            : clock, asynchronous active-low reset
//   d_addr               : byte address (bits [1:0] ignored)
//   d_wr_req, d_be,
//   d_wr_data            : write request, lane enables, lane-aligned data
//   d_wr_ready           : one-cycle write acknowledge
//   d_rd_req             : read request
//   d_rd_ready, d_rd_data: one-cycle read acknowledge and its word
//   busy                 : an access is in progress
//   err_oob, err_clr     : sticky out-of-window flag and its clear
// Accesses outside the window are acknowledged; reads return zero and
// writes are dropped. Write beats read when both are requested together.
module xrv_dmem_resp #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          DEPTH_LOG2  = 14,
  parameter int          WAIT_CYCLES = 0,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] d_addr,
  input  logic        d_wr_req,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wr_data,
  output logic        d_wr_ready,
  input  logic        d_rd_req,
  output logic        d_rd_ready,
  output logic [31:0] d_rd_data,
  output logic        busy,
  output logic        err_oob,
  input  logic        err_clr
);
  import xrv_pkg::*;

  localparam logic [31:0] WIN_SIZE = 32'd4 << DEPTH_LOG2;
  localparam logic [31:0] WIN_MASK = ~(WIN_SIZE - 32'd1);
  localparam logic [7:0]  CNT_LOAD = (WAIT_CYCLES == 0) ? 8'd0 : 8'(WAIT_CYCLES - 1);

  dmem_state_e           state_q, state_d;
  logic                  opWr_q, opWr_d;
  logic                  hit_q, hit_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  errOob_q, errOob_d;
  logic [31:0]           rdData_q, rdData_d;

  logic                  addrHit;
  logic [DEPTH_LOG2-1:0] addrIdx;
  logic                  opReq;
  logic                  wrFire, rdFire, enterResp;
  logic                  ramRe;
  logic [3:0]            ramWe;
  logic [DEPTH_LOG2-1:0] ramAddr;
  logic [31:0]           ramDout, rdWord;

  assign addrHit = (d_addr & WIN_MASK) == BASE_ADDR;
  assign addrIdx = d_addr[DEPTH_LOG2+1:2];
  // Request line belonging to the latched op; losing it in WAIT aborts.
  assign opReq   = opWr_q ? d_wr_req : d_rd_req;

  // Next-state logic. A read that loses to a simultaneous write is simply
  // seen again in IDLE once the write completes.
  always_comb begin
    state_d = state_q;
    opWr_d  = opWr_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      DM_IDLE: begin
        idx_d = addrIdx;
        if (d_wr_req || d_rd_req) begin
          opWr_d = d_wr_req;
          hit_d  = addrHit;
          if (WAIT_CYCLES == 0) begin
            state_d = DM_RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = DM_WAIT;
          end
        end
      end
      DM_WAIT: begin
        if (!opReq) begin
          state_d = DM_IDLE;
        end else if (cnt_q == 8'd0) begin
          state_d = DM_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DM_RESP: state_d = DM_IDLE;
      default: state_d = DM_IDLE;
    endcase
  end

  // RESP always follows IDLE or WAIT, so entering it is a single condition.
  assign enterResp = (state_d == DM_RESP);

  // Ready is gated by its request so it can never appear without one.
  assign wrFire = (state_q == DM_RESP) && opWr_q && d_wr_req;
  assign rdFire = (state_q == DM_RESP) && !opWr_q && d_rd_req;

  // RAM port sharing: reads launch on the edge entering RESP and use the
  // index being latched; writes commit on the edge leaving RESP.
  assign ramRe   = enterResp && !opWr_d && hit_d;
  assign ramWe   = {4{wrFire && hit_q}} & d_be;
  assign ramAddr = (state_q == DM_RESP) ? idx_q : idx_d;

  xrv_dmem_ram #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk    (clk),
    .addr_i (ramAddr),
    .we_i   (ramWe),
    .re_i   (ramRe),
    .wdata_i(d_wr_data),
    .rdata_o(ramDout)
  );

  // Read word is presented live in RESP and captured so it holds afterwards
  // even though the RAM output register itself is not reset.
  assign rdWord   = hit_q ? ramDout : DMEM_MISS_DATA;
  assign rdData_d = rdFire ? rdWord : rdData_q;

  // Flag is raised on the edge into RESP so it is visible with the ready;
  // a new miss overrides a simultaneous clear.
  assign errOob_d = (enterResp && !hit_d) || (errOob_q && !err_clr);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= DM_IDLE;
      opWr_q   <= 1'b0;
      hit_q    <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= 8'd0;
      errOob_q <= 1'b0;
      rdData_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      opWr_q   <= opWr_d;
      hit_q    <= hit_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      errOob_q <= errOob_d;
      rdData_q <= rdData_d;
    end
  end

  assign d_wr_ready = wrFire;
  assign d_rd_ready = rdFire;
  assign d_rd_data  = rdFire ? rdWord : rdData_q;
  assign busy       = (state_q != DM_IDLE);
  assign err_oob    = errOob_q;

endmodule

// File: tb/tb_xrv_dmem_resp.sv
// tb_xrv_dmem_resp: two responders (no wait states and three wait states)
// driven by directed and random accesses; a negedge monitor compares every
// acknowledge against expectations queued when each access was issued.
module tb_xrv_dmem_resp;

  localparam logic [31:0] BASE = 32'h0001_0000;

  typedef struct {
    bit          isWr;
    bit          miss;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rstbA    [2];
  logic [31:0] addrA    [2];
  logic        wrReqA   [2];
  logic [3:0]  beA      [2];
  logic [31:0] wdA      [2];
  logic        wrReadyA [2];
  logic        rdReqA   [2];
  logic        rdReadyA [2];
  logic [31:0] rdDataA  [2];
  logic        busyA    [2];
  logic        errA     [2];
  logic        errClrA  [2];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t expQ0 [$];
  exp_t expQ1 [$];
  logic [31:0] mdl [int];
  exp_t monE;

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xrv_dmem_resp #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rstb(rstbA[0]), .d_addr(addrA[0]), .d_wr_req(wrReqA[0]),
    .d_be(beA[0]), .d_wr_data(wdA[0]), .d_wr_ready(wrReadyA[0]),
    .d_rd_req(rdReqA[0]), .d_rd_ready(rdReadyA[0]), .d_rd_data(rdDataA[0]),
    .busy(busyA[0]), .err_oob(errA[0]), .err_clr(errClrA[0])
  );

  xrv_dmem_resp #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rstb(rstbA[1]), .d_addr(addrA[1]), .d_wr_req(wrReqA[1]),
    .d_be(beA[1]), .d_wr_data(wdA[1]), .d_wr_ready(wrReadyA[1]),
    .d_rd_req(rdReqA[1]), .d_rd_ready(rdReadyA[1]), .d_rd_data(rdDataA[1]),
    .busy(busyA[1]), .err_oob(errA[1]), .err_clr(errClrA[1])
  );

  function automatic int waitOf(input int u);
    return (u == 0) ? 0 : 3;
  endfunction

  function automatic bit inWin(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h0001_0000);
  endfunction

  function automatic int keyOf(input int u, input logic [31:0] a);
    return u * 1000000 + int'((a - BASE) >> 2);
  endfunction

  function automatic void pushExp(input int u, input exp_t e);
    if (u == 0) expQ0.push_back(e);
    else        expQ1.push_back(e);
  endfunction

  function automatic int qSize(input int u);
    return (u == 0) ? expQ0.size() : expQ1.size();
  endfunction

  function automatic exp_t popExp(input int u);
    if (u == 0) return expQ0.pop_front();
    return expQ1.pop_front();
  endfunction

  function automatic void checkOutput(input string name, input logic [31:0] act,
                                      input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  // Reference memory: word-granular, lanes merged from the enables
  function automatic void modelWrite(input int u, input logic [31:0] a,
                                     input logic [3:0] be, input logic [31:0] d);
    logic [31:0] w;
    int k;
    k = keyOf(u, a);
    w = mdl.exists(k) ? mdl[k] : 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
    mdl[k] = w;
  endfunction

  function automatic logic [31:0] modelRead(input int u, input logic [31:0] a);
    if (!inWin(a)) return 32'h0;
    return mdl[keyOf(u, a)];
  endfunction

  // Wait (bounded) for an acknowledge, then drop the request on the next edge
  task automatic waitReady(input int u, input bit isWr);
    bit seen;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = isWr ? wrReadyA[u] : rdReadyA[u];
    end
    if (!seen) checkOutput($sformatf("u%0d ready timeout", u), 32'd0, 32'd1);
    @(posedge clk); #1;
    if (isWr) wrReqA[u] = 1'b0;
    else      rdReqA[u] = 1'b0;
  endtask

  // Issue one access (write, read, or both) and queue its expectations
  task automatic applyStimulus(input int u, input bit doWr, input bit doRd,
                               input logic [31:0] a, input logic [3:0] be,
                               input logic [31:0] d, input bit b2b);
    exp_t e;
    int n0;
    if (!b2b) begin
      @(posedge clk); #1;
    end
    addrA[u] = a; beA[u] = be; wdA[u] = d;
    wrReqA[u] = doWr; rdReqA[u] = doRd;
    n0 = cyc;
    if (doWr) begin
      e.isWr = 1; e.miss = !inWin(a); e.data = 32'h0;
      e.cyc = n0 + 1 + waitOf(u);
      pushExp(u, e);
      if (inWin(a)) modelWrite(u, a, be, d);
    end
    if (doRd) begin
      e.isWr = 0; e.miss = !inWin(a); e.data = modelRead(u, a);
      e.cyc = doWr ? n0 + 3 + 2 * waitOf(u) : n0 + 1 + waitOf(u);
      pushExp(u, e);
    end
    if (doWr) waitReady(u, 1);
    if (doRd) waitReady(u, 0);
  endtask

  // Monitor: every acknowledge must match the head of its unit's queue
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rdReadyA[u] || wrReadyA[u]) begin
        checkOutput($sformatf("u%0d single ready", u),
                    {31'b0, rdReadyA[u] & wrReadyA[u]}, 32'd0);
        if (qSize(u) == 0) begin
          checkOutput($sformatf("u%0d unexpected ready", u), 32'd1, 32'd0);
        end else begin
          monE = popExp(u);
          checkOutput($sformatf("u%0d ready kind", u), {31'b0, wrReadyA[u]},
                      {31'b0, monE.isWr});
          checkOutput($sformatf("u%0d ready cycle", u), 32'(cyc), 32'(monE.cyc));
          if (!monE.isWr)
            checkOutput($sformatf("u%0d rd data", u), rdDataA[u], monE.data);
          if (monE.miss)
            checkOutput($sformatf("u%0d err_oob on miss", u), {31'b0, errA[u]}, 32'd1);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence
  initial begin
    logic [31:0] pool [8];
    logic [31:0] a;
    int n0, r;
    for (int u = 0; u < 2; u++) begin
      rstbA[u] = 0; addrA[u] = 0; wrReqA[u] = 0; rdReqA[u] = 0;
      beA[u] = 0; wdA[u] = 0; errClrA[u] = 0;
    end
    #7;
    for (int u = 0; u < 2; u++) begin
      checkOutput($sformatf("u%0d reset rd_data", u), rdDataA[u], 32'h0);
      checkOutput($sformatf("u%0d reset busy", u), {31'b0, busyA[u]}, 32'd0);
      checkOutput($sformatf("u%0d reset err", u), {31'b0, errA[u]}, 32'd0);
      checkOutput($sformatf("u%0d reset rdy", u),
                  {30'b0, wrReadyA[u], rdReadyA[u]}, 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    rstbA[0] = 1; rstbA[1] = 1;

    // Store then load
    applyStimulus(0, 1, 0, 32'h0001_0010, 4'hF, 32'hCAFE_BABE, 0);
    applyStimulus(0, 0, 1, 32'h0001_0010, 4'h0, 32'h0, 1);
    repeat (3) @(negedge clk);
    checkOutput("rd_data held", rdDataA[0], 32'hCAFE_BABE);

    // Byte lanes
    applyStimulus(0, 1, 0, 32'h0001_0020, 4'hF, 32'h1122_3344, 0);
    applyStimulus(0, 1, 0, 32'h0001_0020, 4'h4, 32'h00AA_0000, 0);
    applyStimulus(0, 0, 1, 32'h0001_0020, 4'h0, 32'h0, 0);
    applyStimulus(0, 1, 0, 32'h0001_0022, 4'hC, 32'hBEEF_0000, 1);
    applyStimulus(0, 0, 1, 32'h0001_0020, 4'h0, 32'h0, 0);
    // Zero lane enables: acked, no change
    applyStimulus(0, 1, 0, 32'h0001_0020, 4'h0, 32'hFFFF_FFFF, 0);
    applyStimulus(0, 0, 1, 32'h0001_0020, 4'h0, 32'h0, 0);

    // Out of range
    applyStimulus(0, 1, 0, 32'h0001_0000, 4'hF, 32'hDEAD_BEEF, 0);
    applyStimulus(0, 0, 1, 32'h0000_0100, 4'h0, 32'h0, 0);
    applyStimulus(0, 1, 0, 32'h0002_0000, 4'hF, 32'h1234_5678, 0);
    applyStimulus(0, 0, 1, 32'h0001_0000, 4'h0, 32'h0, 0);
    @(negedge clk);
    checkOutput("err sticky", {31'b0, errA[0]}, 32'd1);
    @(posedge clk); #1;
    errClrA[0] = 1;
    @(posedge clk); #1;
    errClrA[0] = 0;
    @(negedge clk);
    checkOutput("err cleared", {31'b0, errA[0]}, 32'd0);

    // Simultaneous write and read
    applyStimulus(0, 1, 1, 32'h0001_0010, 4'hF, 32'h5A5A_5A5A, 0);
    applyStimulus(1, 1, 1, 32'h0001_0030, 4'hF, 32'hA5A5_0F0F, 0);

    // Wait-state timing and busy window
    applyStimulus(1, 1, 0, 32'h0001_0010, 4'hF, 32'h0C0F_FEE0, 0);
    @(posedge clk); #1;
    addrA[1] = 32'h0001_0010; rdReqA[1] = 1;
    n0 = cyc;
    monE.isWr = 0; monE.miss = 0; monE.data = 32'h0C0F_FEE0; monE.cyc = n0 + 4;
    pushExp(1, monE);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("busy at T+%0d", k), {31'b0, busyA[1]},
                  (k >= 1) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    rdReqA[1] = 0;
    @(negedge clk);
    checkOutput("busy after resp", {31'b0, busyA[1]}, 32'd0);

    // Reset during the wait states of a write
    applyStimulus(1, 1, 0, 32'h0001_0040, 4'hF, 32'h0BAD_F00D, 0);
    @(posedge clk); #1;
    addrA[1] = 32'h0001_0040; beA[1] = 4'hF; wdA[1] = 32'hFFFF_FFFF; wrReqA[1] = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstbA[1] = 0;
    #1;
    checkOutput("mid reset busy", {31'b0, busyA[1]}, 32'd0);
    checkOutput("mid reset rd_data", rdDataA[1], 32'h0);
    wrReqA[1] = 0;
    @(posedge clk); #1;
    rstbA[1] = 1;
    applyStimulus(1, 0, 1, 32'h0001_0040, 4'h0, 32'h0, 0);

    // Request dropped during wait states: abort, no ack, flag untouched
    @(posedge clk); #1;
    addrA[1] = 32'h0000_0100; rdReqA[1] = 1;
    @(posedge clk); #1;
    rdReqA[1] = 0;
    repeat (6) @(negedge clk);
    checkOutput("abort busy", {31'b0, busyA[1]}, 32'd0);
    checkOutput("abort err", {31'b0, errA[1]}, 32'd0);

    // Random traffic against the reference model
    for (int k = 0; k < 8; k++) pool[k] = BASE + 32'(k * 37 * 4);
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 8; k++)
        applyStimulus(u, 1, 0, pool[k], 4'hF, $urandom, 0);
      for (int n = 0; n < 150; n++) begin
        r = $urandom_range(0, 9);
        a = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
        if (r == 0) begin
          a = ($urandom & 1) ? 32'h0000_0100 : 32'h0002_0000 + 32'($urandom_range(0, 255));
          applyStimulus(u, ($urandom & 1) == 1, 1'b1, a, 4'($urandom), $urandom, ($urandom & 1) == 1);
        end else if (r == 1) begin
          applyStimulus(u, 1, 1, a, 4'($urandom), $urandom, ($urandom & 1) == 1);
        end else if (r <= 5) begin
          applyStimulus(u, 1, 0, a, 4'($urandom), $urandom, ($urandom & 1) == 1);
        end else begin
          applyStimulus(u, 0, 1, a, 4'h0, 32'h0, ($urandom & 1) == 1);
        end
      end
    end

    repeat (10) @(negedge clk);
    checkOutput("u0 queue drained", 32'(qSize(0)), 32'd0);
    checkOutput("u1 queue drained", 32'(qSize(1)), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
